// File: rtl/cos_taylor_if.sv
// Operand/result handshake bundle for cos_taylor_n.
// in_sin exists only when COS_TAYLOR_SIN_EN is defined.
interface cos_taylor_if;
  logic [31:0] in_rad;
  logic        in_stb;
  logic        in_ack;
`ifdef COS_TAYLOR_SIN_EN
  logic        in_sin;
`endif
  logic [31:0] out_z;
  logic        out_stb;
  logic        out_ack;

  modport slave (
    input  in_rad,
    input  in_stb,
`ifdef COS_TAYLOR_SIN_EN
    input  in_sin,
`endif
    input  out_ack,
    output in_ack,
    output out_z,
    output out_stb
  );

  modport master (
    output in_rad,
    output in_stb,
`ifdef COS_TAYLOR_SIN_EN
    output in_sin,
`endif
    output out_ack,
    input  in_ack,
    input  out_z,
    input  out_stb
  );
endinterface

// File: rtl/cos_taylor_n.sv
// Horner-form Taylor cosine over one shared fp multiplier and adder.
// Define COS_TAYLOR_SIN_EN to add the sine table, in_sin and the FIN step.
module fp_op2x32 #(
  parameter bit ADD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  typedef enum logic [1:0] {GET, CALC, PUT} op_t;
  op_t         st;
  logic [31:0] a, b;
  logic        ga, gb;

  // Round-to-nearest-even; subnormals flush to zero.
  function automatic logic [31:0] fmul(
    input logic [31:0] x, input logic [31:0] y);
    logic        s, g, sk;
    logic [47:0] p;
    logic [23:0] m;
    logic [24:0] r;
    int          e;
    s = x[31] ^ y[31];
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; sk = |p[22:0]; e = e + 1;
    end else begin
      m = p[46:23]; g = p[22]; sk = |p[21:0];
    end
    r = {1'b0, m} + {24'd0, g & (sk | m[0])};
    if (r[24]) begin
      r = r >> 1; e = e + 1;
    end
    fmul = {s, e[7:0], r[22:0]};
    if (e <= 0) fmul = {s, 31'd0};
    if (e >= 255) fmul = {s, 8'hff, 23'd0};
    if (x[30:23] == 8'hff || y[30:23] == 8'hff) begin
      if ((x[30:23] == 8'hff && x[22:0] != 0) ||
          (y[30:23] == 8'hff && y[22:0] != 0) ||
          x[30:23] == 8'd0 || y[30:23] == 8'd0)
        fmul = 32'h7fc00000;
      else
        fmul = {s, 8'hff, 23'd0};
    end else if (x[30:23] == 8'd0 || y[30:23] == 8'd0) begin
      fmul = {s, 31'd0};
    end
  endfunction

  function automatic logic [31:0] fadd(
    input logic [31:0] p, input logic [31:0] q);
    logic [31:0] x, y;
    logic [50:0] t;
    logic [26:0] mx, my, n;
    logic [27:0] s;
    logic [24:0] r;
    logic        g, sk;
    int          d, e, lz;
    if (p[30:0] >= q[30:0]) begin
      x = p; y = q;
    end else begin
      x = q; y = p;
    end
    d = int'(x[30:23]) - int'(y[30:23]);
    if (d > 31) d = 31;
    t  = {1'b1, y[22:0], 27'd0} >> d;
    mx = {1'b1, x[22:0], 3'd0};
    my = {t[50:25], |t[24:0]};
    e  = int'(x[30:23]);
    if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
    else                s = {1'b0, mx} - {1'b0, my};
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]}; e = e + 1;
    end else begin
      lz = 0;
      for (int i = 0; i < 27; i++) if (s[i]) lz = 26 - i;
      n = s[26:0] << lz;
      e = e - lz;
    end
    g  = n[2];
    sk = n[1] | n[0];
    r  = {1'b0, n[26:3]} + {24'd0, g & (sk | n[3])};
    if (r[24]) begin
      r = r >> 1; e = e + 1;
    end
    fadd = {x[31], e[7:0], r[22:0]};
    if (e <= 0) fadd = {x[31], 31'd0};
    if (e >= 255) fadd = {x[31], 8'hff, 23'd0};
    if (s == 28'd0) fadd = 32'h0;
    if (x[30:23] == 8'hff) begin
      if (x[22:0] != 0 || (y[30:23] == 8'hff && x[31] != y[31]))
        fadd = 32'h7fc00000;
      else
        fadd = x;
    end else if (y[30:23] == 8'd0) begin
      fadd = x;
    end
  endfunction

  assign input_a_ack = (st == GET) && !ga;
  assign input_b_ack = (st == GET) && !gb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= GET;
      a <= '0;
      b <= '0;
      ga <= 1'b0;
      gb <= 1'b0;
      output_z <= '0;
      output_z_stb <= 1'b0;
    end else begin
      unique case (st)
        GET: begin
          if (input_a_stb && !ga) begin
            a <= input_a; ga <= 1'b1;
          end
          if (input_b_stb && !gb) begin
            b <= input_b; gb <= 1'b1;
          end
          if (ga && gb) st <= CALC;
        end
        CALC: begin
          output_z <= ADD ? fadd(a, b) : fmul(a, b);
          output_z_stb <= 1'b1;
          st <= PUT;
        end
        PUT: if (output_z_ack) begin
          output_z_stb <= 1'b0;
          ga <= 1'b0;
          gb <= 1'b0;
          st <= GET;
        end
        default: st <= GET;
      endcase
    end
  end
endmodule

module cos_taylor_n #(
  parameter int N_TERMS = 3
) (
  input logic clk,
  input logic rst_n,
  cos_taylor_if.slave io
);
  typedef enum logic [2:0] {
    IDLE, SQ, MUL, ADD,
`ifdef COS_TAYLOR_SIN_EN
    FIN,
`endif
    DONE
  } st_t;

  localparam logic [2:0] KT = 3'(N_TERMS - 1);
  localparam logic [2:0] K0 = 3'(N_TERMS - 2);

  st_t         st;
  logic        rst;
  logic [31:0] x, x2, acc;
  logic [2:0]  k;
  logic        sin_q, sin_in;
  logic [31:0] m_a, m_b, m_z, a_a, a_b, a_z;
  logic        m_a_stb, m_b_stb, m_a_ack, m_b_ack;
  logic        m_z_stb, m_z_ack;
  logic        a_a_stb, a_b_stb, a_a_ack, a_b_ack;
  logic        a_z_stb, a_z_ack;

  assign rst = ~rst_n;
`ifdef COS_TAYLOR_SIN_EN
  assign sin_in = io.in_sin;
`else
  assign sin_in = 1'b0;
  assign sin_q  = 1'b0;
`endif

  // sel = {sine, index}
  function automatic logic [31:0] coef(input logic [3:0] sel);
    case (sel)
      4'h0: coef = 32'h3f800000;
      4'h1: coef = 32'hbf000000;
      4'h2: coef = 32'h3d2aaaab;
      4'h3: coef = 32'hbab60b61;
      4'h4: coef = 32'h37d00d01;
      4'h5: coef = 32'hb493f27e;
`ifdef COS_TAYLOR_SIN_EN
      4'h8: coef = 32'h3f800000;
      4'h9: coef = 32'hbe2aaaab;
      4'ha: coef = 32'h3c088889;
      4'hb: coef = 32'hb9500d01;
      4'hc: coef = 32'h3638ef1d;
      4'hd: coef = 32'hb2d7322b;
`endif
      default: coef = 32'h0;
    endcase
  endfunction

  fp_op2x32 #(.ADD(1'b0)) u_mult (
    .clk(clk), .rst(rst),
    .input_a(m_a), .input_a_stb(m_a_stb), .input_a_ack(m_a_ack),
    .input_b(m_b), .input_b_stb(m_b_stb), .input_b_ack(m_b_ack),
    .output_z(m_z), .output_z_stb(m_z_stb), .output_z_ack(m_z_ack)
  );

  fp_op2x32 #(.ADD(1'b1)) u_add (
    .clk(clk), .rst(rst),
    .input_a(a_a), .input_a_stb(a_a_stb), .input_a_ack(a_a_ack),
    .input_b(a_b), .input_b_stb(a_b_stb), .input_b_ack(a_b_ack),
    .output_z(a_z), .output_z_stb(a_z_stb), .output_z_ack(a_z_ack)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      io.in_ack <= 1'b0;
      io.out_stb <= 1'b0;
      io.out_z <= '0;
      x <= '0;
      x2 <= '0;
      acc <= '0;
      k <= '0;
`ifdef COS_TAYLOR_SIN_EN
      sin_q <= 1'b0;
`endif
      m_a <= '0;
      m_b <= '0;
      a_a <= '0;
      a_b <= '0;
      m_a_stb <= 1'b0;
      m_b_stb <= 1'b0;
      a_a_stb <= 1'b0;
      a_b_stb <= 1'b0;
      m_z_ack <= 1'b0;
      a_z_ack <= 1'b0;
    end else begin
      if (m_a_stb && m_a_ack) m_a_stb <= 1'b0;
      if (m_b_stb && m_b_ack) m_b_stb <= 1'b0;
      if (a_a_stb && a_a_ack) a_a_stb <= 1'b0;
      if (a_b_stb && a_b_ack) a_b_stb <= 1'b0;
      m_z_ack <= 1'b0;
      a_z_ack <= 1'b0;
      unique case (st)
        IDLE: begin
          if (io.in_stb && io.in_ack) begin
            x <= io.in_rad;
`ifdef COS_TAYLOR_SIN_EN
            sin_q <= io.in_sin;
`endif
            io.in_ack <= 1'b0;
            k <= K0;
            acc <= coef({sin_in, KT});
            m_a <= io.in_rad;
            m_b <= io.in_rad;
            m_a_stb <= 1'b1;
            m_b_stb <= 1'b1;
            st <= SQ;
          end else begin
            io.in_ack <= 1'b1;
          end
        end
        SQ: if (m_z_stb && !m_z_ack) begin
          m_z_ack <= 1'b1;
          x2 <= m_z;
          m_a <= acc;
          m_b <= m_z;
          m_a_stb <= 1'b1;
          m_b_stb <= 1'b1;
          st <= MUL;
        end
        MUL: if (m_z_stb && !m_z_ack) begin
          m_z_ack <= 1'b1;
          a_a <= m_z;
          a_b <= coef({sin_q, k});
          a_a_stb <= 1'b1;
          a_b_stb <= 1'b1;
          st <= ADD;
        end
        ADD: if (a_z_stb && !a_z_ack) begin
          a_z_ack <= 1'b1;
          acc <= a_z;
          if (k == 3'd0) begin
`ifdef COS_TAYLOR_SIN_EN
            if (sin_q) begin
              m_a <= a_z;
              m_b <= x;
              m_a_stb <= 1'b1;
              m_b_stb <= 1'b1;
              st <= FIN;
            end else begin
              io.out_z <= a_z;
              io.out_stb <= 1'b1;
              st <= DONE;
            end
`else
            io.out_z <= a_z;
            io.out_stb <= 1'b1;
            st <= DONE;
`endif
          end else begin
            k <= k - 3'd1;
            m_a <= a_z;
            m_b <= x2;
            m_a_stb <= 1'b1;
            m_b_stb <= 1'b1;
            st <= MUL;
          end
        end
`ifdef COS_TAYLOR_SIN_EN
        FIN: if (m_z_stb && !m_z_ack) begin
          m_z_ack <= 1'b1;
          acc <= m_z;
          io.out_z <= m_z;
          io.out_stb <= 1'b1;
          st <= DONE;
        end
`endif
        DONE: if (io.out_ack) begin
          io.out_stb <= 1'b0;
          io.in_ack <= 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cos_taylor_n.sv
// Bench for cos_taylor_n: N_TERMS=2 and N_TERMS=3 instances, directed
// cases plus random operands against a real-valued Horner reference.
module tb_cos_taylor_n;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cos_taylor_if b2();
  cos_taylor_if b3();

  logic [31:0] rad [2];
  logic        stb [2];
  logic        oack [2];
  logic        iack [2];
  logic        ostb [2];
  logic [31:0] oz [2];
`ifdef COS_TAYLOR_SIN_EN
  logic        sn [2];
  assign b2.in_sin = sn[0];
  assign b3.in_sin = sn[1];
`endif

  assign b2.in_rad  = rad[0];
  assign b2.in_stb  = stb[0];
  assign b2.out_ack = oack[0];
  assign b3.in_rad  = rad[1];
  assign b3.in_stb  = stb[1];
  assign b3.out_ack = oack[1];
  assign iack[0] = b2.in_ack;
  assign iack[1] = b3.in_ack;
  assign ostb[0] = b2.out_stb;
  assign ostb[1] = b3.out_stb;
  assign oz[0]   = b2.out_z;
  assign oz[1]   = b3.out_z;

  cos_taylor_n #(.N_TERMS(2)) u2 (.clk(clk), .rst_n(rst_n), .io(b2.slave));
  cos_taylor_n #(.N_TERMS(3)) u3 (.clk(clk), .rst_n(rst_n), .io(b3.slave));

  logic [31:0] CT [6] = '{32'h3f800000, 32'hbf000000, 32'h3d2aaaab,
                          32'hbab60b61, 32'h37d00d01, 32'hb493f27e};
  logic [31:0] ST [6] = '{32'h3f800000, 32'hbe2aaaab, 32'h3c088889,
                          32'hb9500d01, 32'h3638ef1d, 32'hb2d7322b};

  int n_pass = 0;
  int n_tot  = 0;

  function automatic real f2r(input logic [31:0] b);
    real m, v;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    v = m * (2.0 ** (real'(int'(b[30:23])) - 127.0));
    return b[31] ? -v : v;
  endfunction

  function automatic real ref_val(input int n, input real x, input bit s);
    real acc, x2;
    x2 = x * x;
    acc = f2r(s ? ST[n-1] : CT[n-1]);
    for (int k = n - 2; k >= 0; k--)
      acc = acc * x2 + f2r(s ? ST[k] : CT[k]);
    if (s) acc = acc * x;
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic chk_ulp(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    int d;
    d = int'(obs) - int'(exp);
    n_tot++;
    assert (obs[31] == exp[31] && d <= 1 && d >= -1) n_pass++;
    else $error("FAIL %s: got %h want %h +-1ulp", tag, obs, exp);
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs,
                          input real r);
    real d, tol;
    d = f2r(obs) - r;
    if (d < 0.0) d = -d;
    tol = 1.0e-6 * (1.0 + (r < 0.0 ? -r : r));
    n_tot++;
    assert (d <= tol) n_pass++;
    else $error("FAIL %s: got %h (%f) want %f", tag, obs, f2r(obs), r);
  endtask

  task automatic wait_out(input int i, output logic [31:0] z);
    int n;
    n = 0;
    @(negedge clk);
    while (!ostb[i] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ostb[i]) chk("out_stb_timeout", 32'(ostb[i]), 32'd1);
    z = oz[i];
  endtask

  task automatic send(input int i, input logic [31:0] x, input logic s);
    int n;
    @(negedge clk);
    rad[i] = x;
`ifdef COS_TAYLOR_SIN_EN
    sn[i] = s;
`else
    if (s) chk("sine_unavailable", 32'(s), 32'd0);
`endif
    stb[i] = 1'b1;
    n = 0;
    while (!iack[i] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!iack[i]) chk("in_ack_timeout", 32'(iack[i]), 32'd1);
    @(posedge clk);
    #1 stb[i] = 1'b0;
  endtask

  task automatic xact(input int i, input logic [31:0] x, input logic s,
                      output logic [31:0] z);
    send(i, x, s);
    wait_out(i, z);
    @(negedge clk);
    oack[i] = 1'b1;
    @(posedge clk);
    #1 oack[i] = 1'b0;
  endtask

  function automatic logic [31:0] rnd_x();
    logic [31:0] v;
    v = {1'($urandom_range(0, 1)), 8'($urandom_range(119, 127)),
         23'($urandom)};
    if ($urandom_range(0, 7) == 0) v = 32'h0;
    return v;
  endfunction

  initial begin
    logic [31:0] z, xr;
    int hi;
    for (int i = 0; i < 2; i++) begin
      rad[i] = '0;
      stb[i] = 1'b0;
      oack[i] = 1'b0;
`ifdef COS_TAYLOR_SIN_EN
      sn[i] = 1'b0;
`endif
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ack", 32'(iack[0]), 32'd0);
    chk("rst_out_stb", 32'(ostb[0]), 32'd0);
    chk("rst_out_z", oz[0], 32'h0);
    chk("rst_in_ack_n3", 32'(iack[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ack_first_clk", 32'(iack[0]), 32'd1);
    chk("in_ack_first_clk_n3", 32'(iack[1]), 32'd1);

    xact(0, 32'h00000000, 1'b0, z);
    chk("n2_zero", z, 32'h3f800000);
    xact(0, 32'h3f800000, 1'b0, z);
    chk("n2_one", z, 32'h3f000000);
    xact(1, 32'h3f800000, 1'b0, z);
    chk_ulp("n3_one", z, 32'h3f0aaaab);
    xact(1, 32'h00000000, 1'b0, z);
    chk("n3_zero", z, 32'h3f800000);

    // Stall the result, with the next operand already waiting.
    send(0, 32'h40000000, 1'b0);
    rad[0] = 32'h00000000;
    stb[0] = 1'b1;
    wait_out(0, z);
    chk("bp_first", z, 32'hbf800000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_z_hold", oz[0], 32'hbf800000);
      chk("bp_stb_hold", 32'(ostb[0]), 32'd1);
      chk("bp_in_ack_low", 32'(iack[0]), 32'd0);
    end
    oack[0] = 1'b1;
    @(posedge clk);
    #1 oack[0] = 1'b0;
    @(negedge clk);
    chk("bp_stb_drop", 32'(ostb[0]), 32'd0);
    chk("bp_in_ack_back", 32'(iack[0]), 32'd1);
    @(posedge clk);
    #1 stb[0] = 1'b0;
    wait_out(0, z);
    chk("b2b_second", z, 32'h3f800000);
    @(negedge clk);
    oack[0] = 1'b1;
    @(posedge clk);
    #1 oack[0] = 1'b0;

    // Reset partway through the first MUL.
    send(0, 32'h3f800000, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ack", 32'(iack[0]), 32'd0);
    chk("mid_rst_out_stb", 32'(ostb[0]), 32'd0);
    chk("mid_rst_out_z", oz[0], 32'h0);
    chk("mid_rst_in_ack_n3", 32'(iack[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    xact(0, 32'h3f800000, 1'b0, z);
    chk("post_rst_one", z, 32'h3f000000);
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (ostb[0]) hi++;
    end
    chk("no_stale_result", 32'(hi), 32'd0);

    for (int r = 0; r < 24; r++) begin
      xr = rnd_x();
      xact(r % 2, xr, 1'b0, z);
      chk_near((r % 2) == 0 ? "rand_n2" : "rand_n3", z,
               ref_val(2 + (r % 2), f2r(xr), 1'b0));
    end

`ifdef COS_TAYLOR_SIN_EN
    xact(0, 32'h3f800000, 1'b1, z);
    chk_ulp("sin_n2_one", z, 32'h3f555555);
    for (int r = 0; r < 12; r++) begin
      xr = rnd_x();
      xact(r % 2, xr, 1'b1, z);
      chk_near((r % 2) == 0 ? "rand_sin_n2" : "rand_sin_n3", z,
               ref_val(2 + (r % 2), f2r(xr), 1'b1));
    end
    xact(1, 32'h3f800000, 1'b0, z);
    chk_ulp("cos_after_sin_n3", z, 32'h3f0aaaab);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/cos_taylor_n.md
# cos_taylor_n

Parametrised, handshaked single-precision cosine evaluator using a truncated Taylor series in Horner form. One fp_mult2x32 and one fp_adder_2x32 are time-multiplexed under a small FSM, so term count scales with a parameter rather than with operator instances. The block accepts one operand per transaction on a stb/ack input port and holds the result on a stb/ack output port. It replaces fixed two-term cosine datapaths in the trig front end.

## Interface
- N_TERMS, 3: number of series terms, 2..6. 2 gives 1 − x²/2; 6 runs up to the x¹⁰ term.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. Operator instances get `rst = ~rst_n`.
- in_rad  input  32  IEEE-754 single operand x in radians; no range reduction.
- in_stb  input  1  operand valid.
- in_ack  output  1  block ready. Transfer occurs on a cycle with `in_stb && in_ack`.
- in_sin  input  1  sine select, sampled with in_rad. Present only with COS_TAYLOR_SIN_EN.
- out_z  output  32  IEEE-754 single result.
- out_stb  output  1  result valid.
- out_ack  input  1  consumer accept. Transfer occurs on a cycle with `out_stb && out_ack`.

## Operation
- Cosine coefficients c0..c5: 3f800000, bf000000, 3d2aaaab, bab60b61, 37d00d01, b493f27e.
- Sine coefficients s0..s5: 3f800000, be2aaaab, 3c088889, b9500d01, 3638ef1d, b2d7322b.
- Evaluation sequence:
  - x2 = x·x.
  - acc = c[N_TERMS−1].
  - For k = N_TERMS−2 down to 0: acc = acc·x2, then acc = acc + c[k].
- Sine mode uses s[] and adds a final step acc = acc·x.
- Operator count: 2·N_TERMS − 1 for cosine; 2·N_TERMS for sine.
- FSM states:
  - IDLE: in_ack=1.
    - On transfer: latch x and mode, set k = N_TERMS−2, go SQ.
  - SQ: multiply x·x.
    - On result: x2 is latched.
    - Go MUL.
  - MUL: multiply acc·x2.
    - On result: go ADD.
  - ADD: add acc + coef[k].
    - On result: if k=0, go FIN (sine) or DONE (cosine).
    - Otherwise decrement k and go MUL.
  - FIN: multiply acc·x, then go DONE.
  - DONE: out_stb=1, out_z=acc.
    - On out_ack: go IDLE.
- Operator protocol for each operation:
  - Hold input_a_stb and input_b_stb high with stable operands.
  - Drop each stb independently once its ack is seen.
  - Wait for output_z_stb, capture output_z.
  - Assert output_z_ack for exactly one cycle.
- The unused operator has all stb and ack inputs held low.
- k is a 3-bit counter; it never wraps below 0.
- Arithmetic is pure IEEE single-precision via the shared operators. The block adds no rounding or special-case logic; NaN and Inf propagate as the operators produce them.

## Timing
- Reset values: in_ack=0, out_stb=0, out_z=32'h0, FSM in IDLE.
- in_ack rises the first clock after rst_n deasserts.
- in_ack is low in every state except IDLE: no overlap, one transaction in flight.
- Latency from input transfer to out_stb is the sum of operator latencies, plus 1 cycle per FSM state transition.
- out_z and out_stb are stable while out_ack is low; backpressure is unbounded.
- out_stb deasserts the cycle after the output transfer.
- in_ack reasserts the same cycle as that out_stb deassertion, so back-to-back inputs are accepted.
- in_stb is ignored outside IDLE; in_rad changes mid-computation have no effect.
- rst_n asserted mid-computation:
  - Outputs clear immediately, without waiting for a clock.
  - The FSM returns to IDLE and operator state is discarded.
  - No stale result is emitted after reset.

## Configuration
- COS_TAYLOR_SIN_EN defined:
  - in_sin port exists; coefficient ROM holds both tables; FIN state is implemented.
  - in_sin=1 selects sine.
- COS_TAYLOR_SIN_EN undefined:
  - No in_sin port, no sine table, no FIN state.
  - Cosine only; operator count is always 2·N_TERMS − 1.

## Test plan
- Zero operand: N_TERMS=2, in_rad=00000000 → out_z=3f800000.
- Unit operand: N_TERMS=2, in_rad=3f800000 (1.0) → out_z=3f000000 (0.5).
- Three terms: N_TERMS=3, in_rad=3f800000 → out_z=3f0aaaab (0.541667) ±1 ulp.
- Backpressure and back-to-back:
  - N_TERMS=2, in_rad=40000000 (2.0), out_ack held low 10 cycles → out_z=bf800000 stable throughout, in_ack low.
  - Release out_ack with next in_rad=00000000 already presented → second result 3f800000.
- Mid-operation reset: assert rst_n=0 while in MUL.
  - Outputs and in_ack go 0 without a clock edge.
  - After release, in_rad=3f800000 (N_TERMS=2) → out_z=3f000000 only.
- Sine mode (COS_TAYLOR_SIN_EN): N_TERMS=2, in_sin=1, in_rad=3f800000 → out_z=3f555555 (0.833333) ±1 ulp.
